// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - BCD time inputs and multiplexed display pins
// master = counter chain / board side, slave = scan driver.
interface seg7_scan_driver_if;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic       blink_hour;
  logic       blink_min;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output hour_bcd, min_bcd, blink_hour, blink_min,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  hour_bcd, min_bcd, blink_hour, blink_min,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit common-anode multiplexed 7-segment scan driver
// Latches the HH:MM BCD word once per frame so a digit never tears mid-scan.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 50,
  parameter int LZ_BLANK     = 1
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  disp
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FC_MAX    = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [FW-1:0] r_fc;
  logic          r_blink_phase;
  logic [15:0]   r_snap;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_tick;

  logic          w_slot_end;
  logic          w_frame_end;
  logic          w_blank;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg;

  assign w_slot_end  = (r_presc == PRESC_MAX);
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);

  always_comb begin
    w_nibble = 4'h0;
    case (r_idx)
      2'd0: w_nibble = r_snap[3:0];
      2'd1: w_nibble = r_snap[7:4];
      2'd2: w_nibble = r_snap[11:8];
      2'd3: w_nibble = r_snap[15:12];
      default: w_nibble = 4'h0;
    endcase
  end

  // presc==0 is the anti-ghost gap between digits
  always_comb begin
    w_blank = (r_presc == '0)
           || (r_blink_phase && disp.blink_min  && !r_idx[1])
           || (r_blink_phase && disp.blink_hour &&  r_idx[1])
           || ((LZ_BLANK != 0) && (r_idx == 2'd3) && (r_snap[15:12] == 4'h0));
  end

  always_comb begin
    w_seg = 7'b0111111;
    case (w_nibble)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc       <= '0;
      r_idx         <= 2'd0;
      r_fc          <= '0;
      r_blink_phase <= 1'b0;
      r_snap        <= 16'h0000;
      r_an          <= 4'b1111;
      r_seg         <= 7'b1111111;
      r_dp          <= 1'b1;
      r_frame_tick  <= 1'b0;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
      if (w_slot_end) r_idx <= r_idx + 2'd1;
      if (w_frame_end) r_snap <= {disp.hour_bcd, disp.min_bcd};
      r_frame_tick <= w_frame_end;
      if (r_frame_tick) begin
        if (r_fc == FC_MAX) begin
          r_fc          <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_fc <= r_fc + 1'b1;
        end
      end
      r_an  <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
      r_seg <= w_blank ? 7'b1111111 : w_seg;
      r_dp  <= !(!w_blank && (r_idx == 2'd2));
    end
  end

  assign disp.an         = r_an;
  assign disp.seg        = r_seg;
  assign disp.dp         = r_dp;
  assign disp.frame_tick = r_frame_tick;
endmodule
